systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default `ARRAYWIDTH, the array edge length in PEs; legal range 2..64.
REQ-002 Parameter PASS_W, default 4, the width of the pass-count field.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  job request; sampled in IDLE only.
REQ-006 abort  input  1  synchronous abort; effective in any non-IDLE state.
REQ-007 cfg_passes  input  PASS_W  number of activation passes accumulated per job; 0 is treated as 1.
REQ-008 cfg_relu  input  1  apply relu on the output drain.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a job completes.
REQ-011 out_valid  output  1  high while out_top carries a result row.
REQ-012 The following are outputs of width 1, one line each, each driving the accelerator's enable input of the same name: input_buffer_load_en, input_buffer_out_en, input_buffer_delay_clear, weight_buffer_load_en, weight_buffer_out_en, write_weight_en, output_buffer_load_en, output_buffer_out_en, output_buffer_load_clear, output_buffer_acc_enable, output_buffer_acc_clear, relu_en, softmax_en.

Function
REQ-013 States: IDLE, CLR, W_LOAD, W_WRITE, A_LOAD, COMPUTE, OUT, DONE; encoding is one-hot or binary, designer's choice.
REQ-014 A single phase counter cnt, clog2(3N) bits, is zeroed on every state entry.
REQ-015 IDLE: when start=1, latch cfg_passes (0 becomes 1) and cfg_relu into registers, then go to CLR.
REQ-016 CLR: lasts 1 cycle; output_buffer_load_clear=1, output_buffer_acc_clear=1, pass counter := 0; then go to W_LOAD.
REQ-017 W_LOAD: weight_buffer_load_en=1 for N cycles; then go to W_WRITE.
REQ-018 W_WRITE: weight_buffer_out_en=1 and write_weight_en=1 for N cycles; then go to A_LOAD.
REQ-019 A_LOAD: input_buffer_load_en=1 for N cycles; then go to COMPUTE.
REQ-020 COMPUTE: lasts 3N-2 cycles.
  - input_buffer_out_en=1 for cnt 0..N-1.
  - output_buffer_load_en=1 for cnt 2N-2..3N-3.
  - output_buffer_acc_enable=1 in the same window whenever pass counter > 0.
REQ-021 COMPUTE last cycle: input_buffer_delay_clear=1 and pass counter increments.
  - If the incremented count < latched passes, go to A_LOAD.
  - Otherwise go to OUT.
REQ-022 OUT: output_buffer_out_en=1 and out_valid=1 for N cycles; relu_en = latched cfg_relu; then go to DONE.
REQ-023 DONE: lasts 1 cycle with done=1; then go to IDLE.
REQ-024 softmax_en is constant 0.
REQ-025 All outputs are registered Moore outputs, decoded from the next state and next cnt, so each enable is asserted in the same cycle the FSM occupies its state.
REQ-026 start is ignored while busy=1; cfg_* changes during a job have no effect on that job.
REQ-027 abort=1 in any non-IDLE state: next cycle enters IDLE, with input_buffer_delay_clear, output_buffer_load_clear and output_buffer_acc_clear asserted that cycle; done is not pulsed.
REQ-028 abort and start in the same cycle while in IDLE: start wins; abort is ignored in IDLE.
REQ-029 Job latency from the start-sampling edge to the done pulse is 3N+2+P*(4N-2) cycles, where P is the latched pass count.

Reset
REQ-030 rst=0 asynchronously forces state=IDLE, cnt=0, pass counter=0, latched cfg=0.
REQ-031 While rst=0, every output is 0.
REQ-032 Reset mid-job abandons the job with no done pulse; the first cycle after release is IDLE.

Structure
REQ-033 State encoding localparams and phase-length constants (N, 2N-2, 3N-2) live in the shared config package alongside `ARRAYWIDTH.
REQ-034 One sub-module is natural: ctrl_phase_cnt, a loadable counter with a terminal-count flag, instantiated for cnt and for the pass counter.

Verification
REQ-035 N=4, passes=1, relu=0, start pulse: done asserts exactly 28 cycles after start; weight_buffer_load_en, write_weight_en and input_buffer_load_en are each high exactly 4 cycles; output_buffer_acc_enable never asserts.
REQ-036 N=4, passes=2: done at cycle 42; A_LOAD and COMPUTE occur twice; output_buffer_acc_enable is high for exactly 4 cycles, during the second COMPUTE only.
REQ-037 cfg_passes=0: behaviour is identical to passes=1, with done at cycle 28.
REQ-038 abort asserted at COMPUTE cnt=5: IDLE next cycle, the three clear outputs pulse once, no done pulse, busy=0.
REQ-039 rst=0 asserted mid-OUT: all outputs go to 0 immediately, without waiting for a clock edge; after release, a new start completes a full 28-cycle job.
REQ-040 relu=1 with start re-pulsed while busy: relu_en is high only during the 4 OUT cycles, and the second start is ignored (exactly one done).

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// systolic_ctrl_pkg: shared array size, FSM states and phase lengths
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
package systolic_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLR, W_LOAD, W_WRITE, A_LOAD, COMPUTE, OUT, DONE} state_t;
  function automatic int phase_n(input int n);
    return n;
  endfunction
  function automatic int phase_acc(input int n);
    return 2 * n - 2;
  endfunction
  function automatic int phase_comp(input int n);
    return 3 * n - 2;
  endfunction
endpackage

// File: rtl/systolic_ctrl_phase_cnt.sv
// ctrl_phase_cnt: loadable up-counter with a terminal-count flag
module ctrl_phase_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] q,
  output logic         tc
);
  // load takes priority over increment
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (load) q <= d;
    else if (inc) q <= q + 1'b1;
  assign tc = q == term;
endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences weight load, activation passes and output drain for an NxN array
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int N = `ARRAYWIDTH,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              cfg_relu,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic              input_buffer_load_en,
  output logic              input_buffer_out_en,
  output logic              input_buffer_delay_clear,
  output logic              weight_buffer_load_en,
  output logic              weight_buffer_out_en,
  output logic              write_weight_en,
  output logic              output_buffer_load_en,
  output logic              output_buffer_out_en,
  output logic              output_buffer_load_clear,
  output logic              output_buffer_acc_enable,
  output logic              output_buffer_acc_clear,
  output logic              relu_en,
  output logic              softmax_en
);
  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] LAST_N = CW'(phase_n(N) - 1);
  localparam logic [CW-1:0] ACC_LO = CW'(phase_acc(N));
  localparam logic [CW-1:0] LAST_C = CW'(phase_comp(N) - 1);
  state_t state, ns;
  logic [CW-1:0] cnt, ncnt, last;
  logic [PASS_W-1:0] pass, passes_q;
  logic relu_q, cnt_tc, pass_tc, cnt_load, pass_inc, kill;
  ctrl_phase_cnt #(.W(CW)) u_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .d('0), .inc(1'b1), .term(last), .q(cnt), .tc(cnt_tc)
  );
  ctrl_phase_cnt #(.W(PASS_W)) u_pass (
    .clk(clk), .rst(rst), .load(state == CLR), .d('0), .inc(pass_inc), .term(passes_q - 1'b1),
    .q(pass), .tc(pass_tc)
  );
  // next state and phase count; the pass counter's terminal flag ends the activation loop
  always_comb begin
    kill = abort && state != IDLE;
    last = (state == COMPUTE) ? LAST_C : (state == CLR || state == DONE || state == IDLE) ? '0 : LAST_N;
    ns = state;
    if (kill) ns = IDLE;
    else if (state == IDLE) ns = start ? CLR : IDLE;
    else if (cnt_tc)
      ns = state == CLR ? W_LOAD : state == W_LOAD ? W_WRITE : state == W_WRITE ? A_LOAD :
           state == A_LOAD ? COMPUTE : state == COMPUTE ? (pass_tc ? OUT : A_LOAD) :
           state == OUT ? DONE : IDLE;
    cnt_load = ns != state || state == IDLE;
    ncnt = cnt_load ? '0 : cnt + 1'b1;
    pass_inc = state == COMPUTE && cnt_tc && !kill;
  end
  // state, latched job config and Moore outputs decoded from the upcoming state/count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      passes_q <= '0;
      relu_q <= 1'b0;
      {busy, done, out_valid, input_buffer_load_en, input_buffer_out_en, input_buffer_delay_clear,
       weight_buffer_load_en, weight_buffer_out_en, write_weight_en, output_buffer_load_en,
       output_buffer_out_en, output_buffer_load_clear, output_buffer_acc_enable,
       output_buffer_acc_clear, relu_en} <= '0;
    end else begin
      state <= ns;
      if (state == IDLE && start) begin
        passes_q <= cfg_passes == '0 ? PASS_W'(1) : cfg_passes;
        relu_q <= cfg_relu;
      end
      busy <= ns != IDLE;
      done <= ns == DONE;
      out_valid <= ns == OUT;
      output_buffer_out_en <= ns == OUT;
      relu_en <= ns == OUT && relu_q;
      weight_buffer_load_en <= ns == W_LOAD;
      weight_buffer_out_en <= ns == W_WRITE;
      write_weight_en <= ns == W_WRITE;
      input_buffer_load_en <= ns == A_LOAD;
      input_buffer_out_en <= ns == COMPUTE && ncnt <= LAST_N;
      output_buffer_load_en <= ns == COMPUTE && ncnt >= ACC_LO;
      output_buffer_acc_enable <= ns == COMPUTE && ncnt >= ACC_LO && pass != '0;
      input_buffer_delay_clear <= (ns == COMPUTE && ncnt == LAST_C) || kill;
      output_buffer_load_clear <= ns == CLR || kill;
      output_buffer_acc_clear <= ns == CLR || kill;
    end
  end
  assign softmax_en = 1'b0;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: schedule-model comparison every cycle plus directed literal checks
module tb_systolic_ctrl;
  localparam int N = 4;
  typedef struct packed {
    logic busy, done, out_valid, ib_load, ib_out, ib_dclr, wb_load, wb_out, ww,
          ob_load, ob_out, ob_lclr, ob_aen, ob_aclr, relu, softmax;
  } ow_t;
  logic clk = 0, rst = 0, start = 0, abort = 0, cfg_relu = 0;
  logic [3:0] cfg_passes = 0;
  logic busy, done, out_valid, input_buffer_load_en, input_buffer_out_en, input_buffer_delay_clear,
        weight_buffer_load_en, weight_buffer_out_en, write_weight_en, output_buffer_load_en,
        output_buffer_out_en, output_buffer_load_clear, output_buffer_acc_enable,
        output_buffer_acc_clear, relu_en, softmax_en;
  ow_t dut_w, exp_w = '0;
  ow_t q[$];
  int checks = 0, errors = 0;
  int c_wl, c_ww, c_il, c_ibo, c_acc, c_relu, c_done, first_acc, lat;

  systolic_ctrl #(.N(N), .PASS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_passes(cfg_passes), .cfg_relu(cfg_relu),
    .busy(busy), .done(done), .out_valid(out_valid), .input_buffer_load_en(input_buffer_load_en),
    .input_buffer_out_en(input_buffer_out_en), .input_buffer_delay_clear(input_buffer_delay_clear),
    .weight_buffer_load_en(weight_buffer_load_en), .weight_buffer_out_en(weight_buffer_out_en),
    .write_weight_en(write_weight_en), .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en(output_buffer_out_en), .output_buffer_load_clear(output_buffer_load_clear),
    .output_buffer_acc_enable(output_buffer_acc_enable), .output_buffer_acc_clear(output_buffer_acc_clear),
    .relu_en(relu_en), .softmax_en(softmax_en)
  );

  assign dut_w = {busy, done, out_valid, input_buffer_load_en, input_buffer_out_en, input_buffer_delay_clear,
                  weight_buffer_load_en, weight_buffer_out_en, write_weight_en, output_buffer_load_en,
                  output_buffer_out_en, output_buffer_load_clear, output_buffer_acc_enable,
                  output_buffer_acc_clear, relu_en, softmax_en};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // whole-job timeline: one expected output word per cycle, phase by phase
  task automatic push_job(input int p, input bit r);
    ow_t w;
    w = '0; w.busy = 1; w.ob_lclr = 1; w.ob_aclr = 1; q.push_back(w);
    for (int i = 0; i < N; i++) begin w = '0; w.busy = 1; w.wb_load = 1; q.push_back(w); end
    for (int i = 0; i < N; i++) begin w = '0; w.busy = 1; w.wb_out = 1; w.ww = 1; q.push_back(w); end
    for (int k = 0; k < p; k++) begin
      for (int i = 0; i < N; i++) begin w = '0; w.busy = 1; w.ib_load = 1; q.push_back(w); end
      for (int c = 0; c < 3 * N - 2; c++) begin
        w = '0; w.busy = 1;
        w.ib_out = c < N;
        w.ob_load = c >= 2 * N - 2;
        w.ob_aen = c >= 2 * N - 2 && k > 0;
        w.ib_dclr = c == 3 * N - 3;
        q.push_back(w);
      end
    end
    for (int i = 0; i < N; i++) begin
      w = '0; w.busy = 1; w.ob_out = 1; w.out_valid = 1; w.relu = r; q.push_back(w);
    end
    w = '0; w.busy = 1; w.done = 1; q.push_back(w);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      exp_w = '0;
    end else if (!exp_w.busy && start) begin
      push_job(cfg_passes == 0 ? 1 : int'(cfg_passes), cfg_relu);
      exp_w = q.pop_front();
    end else if (exp_w.busy && abort) begin
      q.delete();
      exp_w = '0; exp_w.ib_dclr = 1; exp_w.ob_lclr = 1; exp_w.ob_aclr = 1;
    end else begin
      exp_w = q.size() != 0 ? q.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (dut_w !== exp_w) begin
      errors++;
      $display("FAIL model_cycle t=%0t got %b expected %b", $time, dut_w, exp_w);
    end
  end

  // called at a negedge; runs 100 cycles, recording latency and per-signal activity
  task automatic run_job(input logic [3:0] p, input bit r, input int rep);
    c_wl = 0; c_ww = 0; c_il = 0; c_ibo = 0; c_acc = 0; c_relu = 0; c_done = 0; first_acc = 0; lat = 0;
    cfg_passes = p; cfg_relu = r; start = 1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = i == rep;
      cfg_passes = 4'($urandom);
      cfg_relu = 1'($urandom);
      c_wl += int'(weight_buffer_load_en);
      c_ww += int'(write_weight_en);
      c_il += int'(input_buffer_load_en);
      c_ibo += int'(input_buffer_out_en);
      c_relu += int'(relu_en);
      if (output_buffer_acc_enable) begin
        c_acc++;
        if (first_acc == 0) first_acc = i;
      end
      if (done) begin
        c_done++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(dut_w), 0);
    rst = 1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_job(4'd1, 1'b0, 0);
    chk("p1_latency", lat, 28);
    chk("p1_wload_cycles", c_wl, 4);
    chk("p1_wwrite_cycles", c_ww, 4);
    chk("p1_aload_cycles", c_il, 4);
    chk("p1_ibout_cycles", c_ibo, 4);
    chk("p1_acc_cycles", c_acc, 0);
    chk("p1_done_count", c_done, 1);

    run_job(4'd2, 1'b0, 0);
    chk("p2_latency", lat, 42);
    chk("p2_aload_cycles", c_il, 8);
    chk("p2_acc_cycles", c_acc, 4);
    chk("p2_acc_first", first_acc, 34);

    run_job(4'd0, 1'b0, 0);
    chk("p0_latency", lat, 28);
    chk("p0_aload_cycles", c_il, 4);

    run_job(4'd1, 1'b1, 5);
    chk("relu_cycles", c_relu, 4);
    chk("repulse_done_count", c_done, 1);
    chk("repulse_latency", lat, 28);

    cfg_passes = 1; cfg_relu = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (18) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_clears", int'({input_buffer_delay_clear, output_buffer_load_clear, output_buffer_acc_clear}), 7);
    chk("abort_no_done", int'(done), 0);
    @(negedge clk);
    chk("abort_clears_drop", int'({input_buffer_delay_clear, output_buffer_load_clear, output_buffer_acc_clear}), 0);
    c_done = 0;
    repeat (40) begin
      @(negedge clk);
      c_done += int'(done);
    end
    chk("abort_done_count", c_done, 0);

    cfg_passes = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (24) @(negedge clk);
    chk("mid_out_valid", int'(out_valid), 1);
    #2 rst = 0;
    #1 chk("async_reset_outputs", int'(dut_w), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    run_job(4'd1, 1'b0, 0);
    chk("post_reset_latency", lat, 28);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 149) == 0;
      cfg_passes = 4'($urandom_range(0, 3));
      cfg_relu = 1'($urandom);
    end
    @(negedge clk);
    start = 0; abort = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
